// File: rtl/data_mem_bridge_pkg.sv
// rtl/data_mem_bridge_pkg.sv - shared constants, state encoding and helpers for the data memory bridge
package data_mem_bridge_pkg;

   localparam int XLEN        = 32;
   localparam int DEF_TIMEOUT = 15;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_DONE   = 2'b10
   } state_t;

   function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/data_mem_bridge_if.sv
// rtl/data_mem_bridge_if.sv - pipeline MEM-stage and RAM-side signal bundle for the data memory bridge
interface data_mem_bridge_if;
   import data_mem_bridge_pkg::*;

   logic            mem_ren;
   logic            mem_wen;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_dout;
   logic            mem_en;
   logic [XLEN-1:0] mem_din;
   logic            mem_stall;
   logic            mem_fault;

   logic            ram_req;
   logic            ram_we;
   logic [XLEN-1:0] ram_addr;
   logic [XLEN-1:0] ram_wdata;
   logic            ram_ack;
   logic [XLEN-1:0] ram_rdata;

   // slave: the bridge itself; master: the pipeline plus the RAM it talks to
   modport slave (
      input  mem_ren, mem_wen, mem_addr, mem_dout, mem_en, ram_ack, ram_rdata,
      output mem_din, mem_stall, mem_fault, ram_req, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output mem_ren, mem_wen, mem_addr, mem_dout, mem_en, ram_ack, ram_rdata,
      input  mem_din, mem_stall, mem_fault, ram_req, ram_we, ram_addr, ram_wdata
   );

endinterface

// File: rtl/data_mem_bridge_access_timer.sv
// rtl/data_mem_bridge_access_timer.sv - saturating ACCESS cycle counter with clear, enable and reached flag
module access_timer
   import data_mem_bridge_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_reached
);

   localparam int W = $clog2(TIMEOUT + 1);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en && (r_count != W'(TIMEOUT))) begin
         r_count <= r_count + W'(1);
      end
   end

   // High during the TIMEOUT-th enabled cycle, so the owner can leave on that edge.
   assign o_reached = (r_count >= W'(TIMEOUT - 1));

endmodule

// File: rtl/data_mem_bridge.sv
// rtl/data_mem_bridge.sv - MEM-stage to single-port RAM bridge with stall, alignment fault and ack timeout
module data_mem_bridge
   import data_mem_bridge_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   data_mem_bridge_if.slave  bus
);

   state_t          r_state;
   logic            r_ram_req;
   logic            r_ram_we;
   logic [XLEN-1:0] r_ram_addr;
   logic [XLEN-1:0] r_ram_wdata;
   logic [XLEN-1:0] r_mem_din;
   logic            r_fault;
   logic            r_both;

   logic w_req;
   logic w_aligned;
   logic w_in_access;
   logic w_timeout;

   assign w_req       = bus.mem_ren | bus.mem_wen;
   assign w_aligned   = is_word_aligned(bus.mem_addr);
   assign w_in_access = (r_state == ST_ACCESS);

   access_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_access_timer (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (!w_in_access),
      .i_en      (w_in_access),
      .o_reached (w_timeout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ram_req   <= 1'b0;
         r_ram_we    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_mem_din   <= '0;
         r_fault     <= 1'b0;
         r_both      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  if (w_aligned) begin
                     r_ram_req   <= 1'b1;
                     r_ram_we    <= bus.mem_wen;
                     r_ram_addr  <= bus.mem_addr;
                     r_ram_wdata <= bus.mem_dout;
                     r_both      <= bus.mem_ren & bus.mem_wen;
                     r_state     <= ST_ACCESS;
                  end else begin
                     r_fault     <= 1'b1;
                     r_mem_din   <= '0;
                     r_state     <= ST_DONE;
                  end
               end
            end
            ST_ACCESS: begin
               // A load+store collision still completes as a write but reports a fault.
               if (bus.ram_ack) begin
                  r_ram_req <= 1'b0;
                  r_ram_we  <= 1'b0;
                  if (!r_ram_we) begin
                     r_mem_din <= bus.ram_rdata;
                  end
                  r_fault   <= r_both;
                  r_state   <= ST_DONE;
               end else if (w_timeout) begin
                  r_ram_req <= 1'b0;
                  r_ram_we  <= 1'b0;
                  r_mem_din <= '0;
                  r_fault   <= 1'b1;
                  r_state   <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (bus.mem_en) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ram_req   = r_ram_req;
   assign bus.ram_we    = r_ram_we;
   assign bus.ram_addr  = r_ram_addr;
   assign bus.ram_wdata = r_ram_wdata;
   assign bus.mem_din   = r_mem_din;
   assign bus.mem_stall = w_req & (r_state != ST_DONE);
   assign bus.mem_fault = r_fault & (r_state == ST_DONE);

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb/tb_data_mem_bridge.sv - self-checking bench for data_mem_bridge against a transaction-level model
module tb_data_mem_bridge;

   localparam int TIMEOUT = 15;

   logic clk = 1'b0;
   logic rst = 1'b0;
   bit   chk_en = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   data_mem_bridge_if bus();

   data_mem_bridge #(.TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: one outstanding RAM access at a time, then a result held until the pipeline advances.
   bit          m_busy  = 1'b0;
   bit          m_ready = 1'b0;
   bit          m_write = 1'b0;
   bit          m_both  = 1'b0;
   bit          m_fault = 1'b0;
   int          m_age   = 0;
   logic [31:0] m_addr  = '0;
   logic [31:0] m_wdata = '0;
   logic [31:0] m_din   = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy  <= 1'b0;
         m_ready <= 1'b0;
         m_fault <= 1'b0;
         m_age   <= 0;
         m_din   <= '0;
      end else if (m_ready) begin
         if (bus.mem_en) m_ready <= 1'b0;
      end else if (m_busy) begin
         m_age <= m_age + 1;
         if (bus.ram_ack) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b1;
            m_fault <= m_both;
            if (!m_write) m_din <= bus.ram_rdata;
         end else if (m_age + 1 == TIMEOUT) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b1;
            m_fault <= 1'b1;
            m_din   <= '0;
         end
      end else if (bus.mem_ren || bus.mem_wen) begin
         if (bus.mem_addr[1:0] != 2'b00) begin
            m_ready <= 1'b1;
            m_fault <= 1'b1;
            m_din   <= '0;
         end else begin
            m_busy  <= 1'b1;
            m_age   <= 0;
            m_write <= bus.mem_wen;
            m_both  <= bus.mem_ren && bus.mem_wen;
            m_addr  <= bus.mem_addr;
            m_wdata <= bus.mem_dout;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("ram_req", 32'(bus.ram_req), 32'(m_busy));
         check("ram_we", 32'(bus.ram_we), 32'(m_busy && m_write));
         if (m_busy) begin
            check("ram_addr", bus.ram_addr, m_addr);
            if (m_write) check("ram_wdata", bus.ram_wdata, m_wdata);
         end
         check("mem_stall", 32'(bus.mem_stall), 32'((bus.mem_ren || bus.mem_wen) && !m_ready));
         check("mem_fault", 32'(bus.mem_fault), 32'(m_ready && m_fault));
         check("mem_din", bus.mem_din, m_din);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step();
      bus.mem_ren  = 1'b0;
      bus.mem_wen  = 1'b0;
      bus.mem_en   = 1'b0;
      bus.ram_ack  = 1'b0;
      bus.mem_addr = '0;
      bus.mem_dout = '0;
   endtask

   // Presents one instruction, acks on the ack_at-th ram_req cycle (0 = never), holds DONE for
   // hold cycles with a stray ack, then raises mem_en so the next edge leaves DONE.
   task automatic do_access(input bit ren, input bit wen, input logic [31:0] addr,
                            input logic [31:0] dout, input int ack_at, input logic [31:0] rdata,
                            input int hold,
                            output int stall_cyc, output int req_cyc, output int req_rises,
                            output int we_cyc, output int hold_bad,
                            output logic fault_seen, output logic [31:0] din_seen);
      bit done = 1'b0;
      bit prev_req = 1'b0;
      stall_cyc = 0;
      req_cyc   = 0;
      req_rises = 0;
      we_cyc    = 0;
      hold_bad  = 0;
      step();
      bus.mem_ren  = ren;
      bus.mem_wen  = wen;
      bus.mem_addr = addr;
      bus.mem_dout = dout;
      bus.mem_en   = 1'b0;
      bus.ram_ack  = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         #2;
         if (bus.mem_stall) stall_cyc++;
         else done = 1'b1;
         if (bus.ram_req) begin
            req_cyc++;
            if (!prev_req) req_rises++;
            if (bus.ram_we && bus.ram_wdata == dout) we_cyc++;
         end
         prev_req      = bus.ram_req;
         bus.ram_ack   = bus.ram_req && (req_cyc == ack_at);
         bus.ram_rdata = bus.ram_ack ? rdata : 32'h0BAD_0BAD;
         if (!done) step();
      end
      check("access_done", 32'(done), 32'd1);
      fault_seen = bus.mem_fault;
      din_seen   = bus.mem_din;
      for (int h = 0; h < hold; h++) begin
         bus.ram_ack   = (h == 0);
         bus.ram_rdata = 32'hFFFF_FFFF;
         step();
         #2;
         if (bus.ram_req || bus.mem_stall || bus.mem_fault !== fault_seen || bus.mem_din !== din_seen)
            hold_bad++;
      end
      bus.ram_ack = 1'b0;
      bus.mem_en  = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int          s, rq, rr, wc, hb;
      logic        f;
      logic [31:0] d;

      bus.mem_ren   = 1'b0;
      bus.mem_wen   = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_dout  = '0;
      bus.mem_en    = 1'b0;
      bus.ram_ack   = 1'b0;
      bus.ram_rdata = '0;
      #2 rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_ram_req", 32'(bus.ram_req), 32'd0);
      check("reset_ram_addr", bus.ram_addr, 32'h0);
      check("reset_mem_din", bus.mem_din, 32'h0);
      check("reset_mem_fault", 32'(bus.mem_fault), 32'd0);
      check("reset_mem_stall", 32'(bus.mem_stall), 32'd0);
      rst    = 1'b0;
      chk_en = 1'b1;

      do_access(1'b1, 1'b0, 32'h10, 32'h0, 3, 32'hDEAD_BEEF, 0, s, rq, rr, wc, hb, f, d);
      check("load_stall_cycles", 32'(s), 32'd4);
      check("load_req_cycles", 32'(rq), 32'd3);
      check("load_req_rises", 32'(rr), 32'd1);
      check("load_fault", 32'(f), 32'd0);
      check("load_din", d, 32'hDEAD_BEEF);
      idle();

      do_access(1'b0, 1'b1, 32'h20, 32'h1234_5678, 2, 32'h0, 0, s, rq, rr, wc, hb, f, d);
      check("store_req_rises", 32'(rr), 32'd1);
      check("store_we_cycles", 32'(wc), 32'd2);
      check("store_stall_cycles", 32'(s), 32'd3);
      check("store_fault", 32'(f), 32'd0);
      check("store_din_held", d, 32'hDEAD_BEEF);
      idle();

      do_access(1'b1, 1'b0, 32'h13, 32'h0, 1, 32'h7777_7777, 0, s, rq, rr, wc, hb, f, d);
      check("misalign_req_rises", 32'(rr), 32'd0);
      check("misalign_stall_cycles", 32'(s), 32'd1);
      check("misalign_fault", 32'(f), 32'd1);
      check("misalign_din", d, 32'h0);
      idle();

      do_access(1'b1, 1'b0, 32'h40, 32'h0, 0, 32'h0, 0, s, rq, rr, wc, hb, f, d);
      check("timeout_req_cycles", 32'(rq), 32'd15);
      check("timeout_stall_cycles", 32'(s), 32'd16);
      check("timeout_fault", 32'(f), 32'd1);
      check("timeout_din", d, 32'h0);
      idle();

      do_access(1'b1, 1'b0, 32'h10, 32'h0, 1, 32'h0BAD_F00D, 3, s, rq, rr, wc, hb, f, d);
      check("hold_din", d, 32'h0BAD_F00D);
      check("hold_fault", 32'(f), 32'd0);
      check("hold_stable", 32'(hb), 32'd0);
      do_access(1'b1, 1'b0, 32'h24, 32'h0, 1, 32'h2424_2424, 0, s, rq, rr, wc, hb, f, d);
      check("b2b_stall_cycles", 32'(s), 32'd2);
      check("b2b_req_rises", 32'(rr), 32'd1);
      check("b2b_din", d, 32'h2424_2424);
      idle();

      do_access(1'b1, 1'b1, 32'h30, 32'hCAFE_0001, 1, 32'h9999_9999, 0, s, rq, rr, wc, hb, f, d);
      check("both_we_cycles", 32'(wc), 32'd1);
      check("both_fault", 32'(f), 32'd1);
      check("both_din_held", d, 32'h2424_2424);
      idle();

      step();
      bus.mem_ren  = 1'b1;
      bus.mem_addr = 32'h50;
      step();
      step();
      #2;
      check("midrst_pre_req", 32'(bus.ram_req), 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_ram_req", 32'(bus.ram_req), 32'd0);
      check("midrst_ram_addr", bus.ram_addr, 32'h0);
      check("midrst_mem_din", bus.mem_din, 32'h0);
      step();
      bus.mem_ren  = 1'b0;
      bus.mem_addr = '0;
      step();
      rst           = 1'b0;
      bus.ram_ack   = 1'b1;
      bus.ram_rdata = 32'h5555_5555;
      step();
      bus.ram_ack = 1'b0;
      #2;
      check("lateack_ram_req", 32'(bus.ram_req), 32'd0);
      check("lateack_mem_din", bus.mem_din, 32'h0);
      check("lateack_mem_stall", 32'(bus.mem_stall), 32'd0);
      check("lateack_mem_fault", 32'(bus.mem_fault), 32'd0);
      check("lateack_ram_wdata", bus.ram_wdata, 32'h0);
      repeat (2) step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
